// File: rtl/fifo_ctrl.sv
// fifo_ctrl -- pointer and flag controller for the fifo_core storage array.
//
// Gates push/pop requests against full/empty, drives the core write/read
// enables and addresses, and reports occupancy and threshold status. The core
// read is combinational at rd_ptr, so head data is valid whenever empty is 0.
//
// Optional feature macro: FIFO_CTRL_ERR_EN
//   defined   -> sticky overflow/underflow flags, cleared by err_clr
//   undefined -> overflow/underflow tied to 0, err_clr ignored
//
// Ports:
//   clk, rst                clock (rising edge), async active-low reset
//   wr_req, rd_req          push / pop requests
//   flush                   sync clear of pointers and count (beats requests)
//   err_clr                 sync clear of sticky error flags
//   wr_en, rd_en            accepted push / pop, to the core
//   wr_ptr, rd_ptr          core write / head address
//   full, empty             status decoded from registered pointers
//   almost_full/empty       count >= AF_LEVEL / count <= AE_LEVEL
//   count                   occupancy 0..DEPTH
//   overflow, underflow     sticky error flags
module fifo_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int AF_LEVEL   = 12,
    parameter int AE_LEVEL   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_req,
    input  logic                  rd_req,
    input  logic                  flush,
    input  logic                  err_clr,
    output logic                  wr_en,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] wr_ptr,
    output logic [ADDR_WIDTH-1:0] rd_ptr,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] AF_LVL  = AF_LEVEL[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AE_LVL  = AE_LEVEL[ADDR_WIDTH:0];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0] count_q,  count_d;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
                   (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);

    // Enables are also held low while reset is asserted so the core sees no
    // writes or pops during reset, matching the reset-state of the outputs.
    assign wr_en = rst & wr_req & ~full  & ~flush;
    assign rd_en = rst & rd_req & ~empty & ~flush;

    assign wr_ptr       = wr_ptr_q[ADDR_WIDTH-1:0];
    assign rd_ptr       = rd_ptr_q[ADDR_WIDTH-1:0];
    assign count        = count_q;
    assign almost_full  = (count_q >= AF_LVL);
    assign almost_empty = (count_q <= AE_LVL);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (rd_en) rd_ptr_d = rd_ptr_q + PTR_ONE;
            // Simultaneous push and pop leave the count unchanged.
            case ({wr_en, rd_en})
                2'b10:   count_d = count_q + PTR_ONE;
                2'b01:   count_d = count_q - PTR_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

`ifdef FIFO_CTRL_ERR_EN
    logic overflow_q,  overflow_d;
    logic underflow_q, underflow_d;

    // Clear first, then set, so a set in the same cycle wins.
    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (err_clr) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (wr_req & full  & ~flush) overflow_d  = 1'b1;
        if (rd_req & empty & ~flush) underflow_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign overflow       = 1'b0;
    assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Testbench for fifo_ctrl: directed sequences followed by randomized traffic,
// every cycle checked against a queue-based reference model. A small storage
// array stands in for fifo_core so data ordering through the pointers is seen.
module tb_fifo_ctrl;

    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_req, rd_req, flush, err_clr;
    logic          wr_en, rd_en, full, empty, almost_full, almost_empty;
    logic          overflow, underflow;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fifo_ctrl #(.ADDR_WIDTH(AW), .AF_LEVEL(12), .AE_LEVEL(2)) dut (
        .clk(clk), .rst(rst), .wr_req(wr_req), .rd_req(rd_req),
        .flush(flush), .err_clr(err_clr), .wr_en(wr_en), .rd_en(rd_en),
        .wr_ptr(wr_ptr), .rd_ptr(rd_ptr), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    // Stand-in core storage: write on wr_en, combinational read at rd_ptr.
    logic [7:0] din;
    logic [7:0] mem [DEPTH];
    logic [7:0] dout;
    always @(posedge clk) if (wr_en) mem[wr_ptr] <= din;
    assign dout = mem[rd_ptr];

    // Reference model: contents queue, accepted push/pop totals, sticky flags.
    logic [7:0] q[$];
    int         wpc, rpc;
    bit         m_ovf, m_unf;
    logic [7:0] dcnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outs(input bit w, input bit r, input bit f);
        int n;
        bit eo, eu;
        n = q.size();
`ifdef FIFO_CTRL_ERR_EN
        eo = m_ovf; eu = m_unf;
`else
        eo = 1'b0;  eu = 1'b0;
`endif
        chk("wr_en",        32'(wr_en),        32'(rst && w && n < DEPTH && !f));
        chk("rd_en",        32'(rd_en),        32'(rst && r && n > 0 && !f));
        chk("wr_ptr",       32'(wr_ptr),       32'(wpc % DEPTH));
        chk("rd_ptr",       32'(rd_ptr),       32'(rpc % DEPTH));
        chk("count",        32'(count),        32'(n));
        chk("full",         32'(full),         32'(n == DEPTH));
        chk("empty",        32'(empty),        32'(n == 0));
        chk("almost_full",  32'(almost_full),  32'(n >= 12));
        chk("almost_empty", 32'(almost_empty), 32'(n <= 2));
        chk("overflow",     32'(overflow),     32'(eo));
        chk("underflow",    32'(underflow),    32'(eu));
        if (n > 0) chk("dout", 32'(dout), 32'(q[0]));
    endtask

    // One clock cycle: drive at the falling edge, check, advance the model.
    task automatic step(input bit w, input bit r, input bit f, input bit e);
        int  n;
        bit  aw, ar;
        wr_req = w; rd_req = r; flush = f; err_clr = e;
        din  = dcnt;
        dcnt = dcnt + 8'd1;
        #1;
        check_outs(w, r, f);
        @(posedge clk);
        n  = q.size();
        aw = w && n < DEPTH && !f;
        ar = r && n > 0 && !f;
        if (f) begin
            q.delete();
            wpc = 0;
            rpc = 0;
        end else begin
            if (ar) begin
                void'(q.pop_front());
                rpc++;
            end
            if (aw) begin
                q.push_back(din);
                wpc++;
            end
        end
        if (w && n == DEPTH && !f) m_ovf = 1'b1;
        else if (e)                m_ovf = 1'b0;
        if (r && n == 0 && !f)     m_unf = 1'b1;
        else if (e)                m_unf = 1'b0;
        @(negedge clk);
    endtask

    task automatic model_reset();
        q.delete();
        wpc = 0; rpc = 0;
        m_ovf = 1'b0; m_unf = 1'b0;
    endtask

    initial begin
        wr_req = 0; rd_req = 0; flush = 0; err_clr = 0;
        din = 0; dcnt = 0;
        model_reset();
        rst = 1'b1;
        #1 rst = 1'b0;
        @(negedge clk);
        check_outs(0, 0, 0);
        rst = 1'b1;

        // Fill to full with 0x00..0x0F; wr_ptr wraps back to 0.
        dcnt = 8'h00;
        for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 0);
        step(1, 0, 0, 0);          // push while full -> dropped, overflow
        step(0, 0, 0, 1);          // err_clr
        step(1, 1, 0, 0);          // full + push + pop -> pop only
        step(1, 0, 0, 0);          // refill to 16

        // Drain completely; data comes out in order.
        for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 0);

        // Count 5, then 40 cycles of simultaneous push and pop.
        for (int i = 0; i < 5; i++)  step(1, 0, 0, 0);
        for (int i = 0; i < 40; i++) step(1, 1, 0, 0);
        for (int i = 0; i < 5; i++)  step(0, 1, 0, 0);

        // Empty-side boundaries.
        step(0, 1, 0, 0);          // pop while empty -> underflow
        step(1, 1, 0, 0);          // empty + push + pop -> push only
        step(0, 0, 0, 1);          // clear errors

        // Count 7, flush with a push: no error, back to empty.
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0);
        step(1, 0, 1, 0);
        step(0, 0, 0, 0);
        step(1, 1, 1, 0);          // requests during flush on empty: no error
        step(0, 0, 0, 0);

        // Randomized traffic with drifting push/pop bias; reset mid-burst.
        for (int i = 0; i < 1500; i++) begin
            int wb;
            wb = ((i / 100) % 2 == 0) ? 70 : 30;
            if (i == 700) begin
                wr_req = 1; rd_req = 1;
                rst = 1'b0;
                #1;
                model_reset();
                check_outs(1, 1, 0);
                @(negedge clk);
                check_outs(1, 1, 0);
                rst = 1'b1;
                wr_req = 0; rd_req = 0;
            end
            step($urandom_range(0, 99) < wb,
                 $urandom_range(0, 99) < (100 - wb),
                 $urandom_range(0, 59) == 0,
                 $urandom_range(0, 24) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
